// File: rtl/alu_op_sequencer.sv
// Operand/result sequencer around the one-hot controlled ALU: Y beat, X beat, one EXEC cycle, then ZLo (+ZHi for mul/div).
// Optional ALU_SEQ_PERF_EN macro adds ops_done / err_cnt counters and their ports.
module alu_op_sequencer #(
  parameter int BITS = 32,
  parameter int OPW  = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_data,
  input  logic [OPW-1:0]    in_op,
  output logic [OPW-1:0]    alu_ctrl,
  output logic [BITS-1:0]   alu_x,
  output logic [BITS-1:0]   alu_y,
  input  logic [2*BITS-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic              out_last,
  output logic              err_op,
  output logic              err_dz
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       ops_done,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_MUL = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV = OPW'(8);
  localparam logic [OPW-1:0] OP_AND = OPW'(256);
  localparam logic [OPW-1:0] OP_OR  = OPW'(512);
  localparam logic [OPW-1:0] LEGAL  = OP_ADD | OP_SUB | OP_MUL | OP_DIV | OP_AND | OP_OR;

  typedef enum logic [2:0] {
    IDLE, LOAD_X, EXEC, WB_LO, WB_HI
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     y_q, y_d, x_q, x_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [2*BITS-1:0]   z_q, z_d;
  logic                err_op_q, err_op_d, err_dz_q, err_dz_d;
  logic                is_md;

  assign is_md  = (op_q & (OP_MUL | OP_DIV)) != '0;
  assign err_op = err_op_q;
  assign err_dz = err_dz_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      y_q      <= '0;
      x_q      <= '0;
      op_q     <= '0;
      z_q      <= '0;
      err_op_q <= 1'b0;
      err_dz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      x_q      <= x_d;
      op_q     <= op_d;
      z_q      <= z_d;
      err_op_q <= err_op_d;
      err_dz_q <= err_dz_d;
    end
  end

  // All handshake and ALU outputs decode from state_q, so reset forces them idle immediately.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    x_d       = x_q;
    op_d      = op_q;
    z_d       = z_q;
    err_op_d  = 1'b0;
    err_dz_d  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    alu_ctrl  = '0;
    alu_x     = '0;
    alu_y     = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          y_d  = in_data;
          op_d = in_op;
          if (!$onehot(in_op) || (in_op & ~LEGAL) != '0)
            err_op_d = 1'b1;
          else if (in_op == OP_DIV && in_data == '0)
            err_dz_d = 1'b1;
          else
            state_d = LOAD_X;
        end
      end
      LOAD_X: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_ctrl = op_q;
        alu_x    = x_q;
        alu_y    = y_q;
        z_d      = alu_result;
        state_d  = WB_LO;
      end
      WB_LO: begin
        out_valid = 1'b1;
        out_data  = z_q[BITS-1:0];
        out_last  = !is_md;
        if (out_ready) state_d = is_md ? WB_HI : IDLE;
      end
      WB_HI: begin
        out_valid = 1'b1;
        out_data  = z_q[2*BITS-1:BITS];
        out_last  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] ops_done_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ops_done_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (out_valid && out_ready && out_last) ops_done_q <= ops_done_q + 16'd1;
      if ((err_op_q || err_dz_q) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ops_done = ops_done_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the alu_* pins, result beats checked against a queue.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [11:0] in_op = '0;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_x, alu_y;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        err_op, err_dz;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] ops_done;
  logic [7:0]  err_cnt;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    n_vec = 0;
  int    n_bad = 0;

  alu_op_sequencer #(.BITS(32), .OPW(12)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_op(err_op), .err_dz(err_dz)
`ifdef ALU_SEQ_PERF_EN
    , .ops_done(ops_done), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: sub is X-Y, div gives {X%Y, X/Y} signed.
  logic signed [63:0] px, py;
  logic signed [31:0] sx, sy;
  always_comb begin
    px = {{32{alu_x[31]}}, alu_x};
    py = {{32{alu_y[31]}}, alu_y};
    sx = alu_x;
    sy = alu_y;
    alu_result = '0;
    case (alu_ctrl)
      12'h001: alu_result = {32'h0, alu_x + alu_y};
      12'h002: alu_result = {32'h0, alu_x - alu_y};
      12'h004: alu_result = px * py;
      12'h008: if (alu_y != 0) alu_result = {32'(sx % sy), 32'(sx / sy)};
      12'h100: alu_result = {32'h0, alu_x & alu_y};
      12'h200: alu_result = {32'h0, alu_x | alu_y};
      default: alu_result = '0;
    endcase
  end

  // Scoreboard: the beat present at a negedge with out_ready high transfers on the next posedge.
  always @(negedge clk) begin
    if (clr && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%h last=%b, none expected", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          n_bad++;
          $display("FAIL beat: got data=%h last=%b, expected data=%h last=%b",
                   out_data, out_last, e.data, e.last);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [11:0] op);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_op = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 40 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_op = '0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, out_valid=%b", exp_q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_last, err_op, err_dz} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_hs: rdy/vld/last/eop/edz=%b, expected 10000",
               {in_ready, out_valid, out_last, err_op, err_dz});
    end
    n_vec++;
    if ({alu_ctrl, alu_x, alu_y} !== 76'h0) begin
      n_bad++;
      $display("FAIL reset_alu: ctrl=%h x=%h y=%h, expected 0", alu_ctrl, alu_x, alu_y);
    end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_err_op();
    logic [11:0] ops [3];
    ops[0] = 12'h003; ops[1] = 12'h000; ops[2] = 12'h400;
    for (int i = 0; i < 3; i++) begin
      send(32'd7, ops[i]);
      @(negedge clk);
      n_vec++;
      if ({err_op, err_dz, out_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL err_op_pulse[%0d]: eop/edz/vld=%b, expected 100", i, {err_op, err_dz, out_valid});
      end
      @(negedge clk);
      n_vec++;
      if ({err_op, out_valid, in_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL err_op_end[%0d]: eop/vld/rdy=%b, expected 001", i, {err_op, out_valid, in_ready});
      end
      @(posedge clk); #1;
    end
`ifdef ALU_SEQ_PERF_EN
    n_vec++;
    if (err_cnt !== 8'd3 || ops_done !== 16'd0) begin
      n_bad++;
      $display("FAIL perf_err: err_cnt=%0d ops_done=%0d, expected 3 and 0", err_cnt, ops_done);
    end
`endif
  endtask

  task automatic test_add();
    exp_q.push_back('{32'h0000_0008, 1'b1});
    send(32'd5, 12'h001);
    send(32'd3, 12'h000);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || alu_ctrl !== 12'h001 || alu_x !== 32'd3 || alu_y !== 32'd5) begin
      n_bad++;
      $display("FAIL add_exec: vld=%b ctrl=%h x=%h y=%h, expected 0 001 3 5", out_valid, alu_ctrl, alu_x, alu_y);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || alu_ctrl !== 12'h000) begin
      n_bad++;
      $display("FAIL add_latency: vld=%b ctrl=%h, expected 1 000", out_valid, alu_ctrl);
    end
    wait_drain();
  endtask

  task automatic test_sub();
    exp_q.push_back('{32'hFFFF_FFFB, 1'b1});
    send(32'd15, 12'h002);
    send(32'd10, 12'h000);
    wait_drain();
    exp_q.push_back('{32'h0000_0014, 1'b1});
    send(32'hFFFF_FFF6, 12'h002);
    send(32'd10, 12'h000);
    wait_drain();
  endtask

  task automatic test_mul_hold();
    bit ok = 0;
    out_ready = 1'b0;
    exp_q.push_back('{32'hFFFF_FFB5, 1'b0});
    exp_q.push_back('{32'hFFFF_FFFF, 1'b1});
    send(32'd5, 12'h004);
    send(32'hFFFF_FFF1, 12'h000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL mul_valid_timeout: out_valid=%b, expected 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFB5 || out_last !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_hold_lo[%0d]: vld=%b data=%h last=%b, expected 1 ffffffb5 0",
                 i, out_valid, out_data, out_last);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_last !== 1'b1) begin
        n_bad++;
        $display("FAIL mul_hold_hi[%0d]: vld=%b data=%h last=%b, expected 1 ffffffff 1",
                 i, out_valid, out_data, out_last);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_div();
    exp_q.push_back('{32'hFFFF_FFFD, 1'b0});
    exp_q.push_back('{32'h0000_0000, 1'b1});
    send(32'd5, 12'h008);
    send(32'hFFFF_FFF1, 12'h000);
    wait_drain();
  endtask

  task automatic test_div_zero();
    send(32'd0, 12'h008);
    @(negedge clk);
    n_vec++;
    if ({err_dz, err_op, out_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL div_zero_pulse: edz/eop/vld=%b, expected 100", {err_dz, err_op, out_valid});
    end
    @(negedge clk);
    n_vec++;
    if ({err_dz, out_valid, in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL div_zero_end: edz/vld/rdy=%b, expected 001", {err_dz, out_valid, in_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{32'h0000_00FF, 1'b1});
    exp_q.push_back('{32'h0000_0003, 1'b1});
    send(32'h0000_00F0, 12'h200);
    send(32'h0000_000F, 12'h000);
    send(32'd1, 12'h001);
    send(32'd2, 12'h000);
    wait_drain();
  endtask

  task automatic test_reset_midop();
    bit ok = 0;
    out_ready = 1'b0;
    send(32'd5, 12'h004);
    send(32'hFFFF_FFF1, 12'h000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midop_wb_lo: out_valid=%b, expected 1", out_valid);
    end
    #2 clr = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_last, in_ready, alu_ctrl} !== 15'b001_000000000000) begin
      n_bad++;
      $display("FAIL midop_async: vld/last/rdy=%b ctrl=%h, expected 001 000",
               {out_valid, out_last, in_ready}, alu_ctrl);
    end
    @(negedge clk);
    clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{32'h0000_0000, 1'b1});
    send(32'd0, 12'h100);
    send(32'hFFFF_FFFF, 12'h000);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_err_op();
    test_add();
    test_sub();
    test_mul_hold();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
